reg_ex_mem: RTL
===============

Name: reg_ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute result each cycle: GPR write, HI/LO write, and load/store operands.
- Inserts bubbles and holds on stall, squashes on flush.
- Carries the two-cycle multiply-accumulate state (hilo_temp, cnt) and feeds it back into execute while execute is stalled.

Parameters:
- none (widths fixed: 32-bit datapath, 5-bit register address, 8-bit aluop)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall_ex  input  1  execute stage stalled this cycle
- stall_mem  input  1  memory stage stalled this cycle
- flush  input  1  squash the instruction entering MEM (exception/redirect)
- valid_i  input  1  execute holds a real instruction
- aluop_i  input  8  execute aluop, needed by MEM for load/store decode
- we_i  input  1  GPR write enable from execute (already overflow-masked)
- waddr_i  input  5  GPR destination
- wdata_i  input  32  GPR write data / link address
- we_hilo_i  input  1  HI/LO write enable
- hi_i  input  32  HI value to write
- lo_i  input  32  LO value to write
- mem_addr_i  input  32  effective address for load/store
- mem_data_i  input  32  store data (rt value)
- hilo_temp_i  input  64  partial product from the first MADD/MSUB cycle
- cnt_i  input  2  accumulate cycle counter from execute
- valid_o, aluop_o, we_o, waddr_o, wdata_o, we_hilo_o, hi_o, lo_o, mem_addr_o, mem_data_o  output  same widths as the matching inputs  registered copies to MEM
- hilo_temp_o  output  64  registered partial product, returned to execute
- cnt_o  output  2  registered counter, returned to execute

Behaviour:
- All outputs are registered; latency is 1 cycle input to output. There is no combinational path.
- Pipeline fields are every output except hilo_temp_o and cnt_o.
- Per-edge priority: rst > flush > stall decode.
- rst=1: every output goes to 0, including valid_o, hilo_temp_o and cnt_o.
- flush=1 (rst=0): every pipeline field goes to 0 and valid_o=0; hilo_temp_o=0 and cnt_o=0. Flush wins over any stall.
- stall_ex=0 (normal advance): every pipeline field loads its input; hilo_temp_o is cleared to 0 and cnt_o is cleared to 0.
- stall_ex=1, stall_mem=0 (bubble):
  - Every pipeline field goes to 0, including we_o, we_hilo_o and valid_o.
  - hilo_temp_o loads hilo_temp_i; cnt_o loads cnt_i.
- stall_ex=1, stall_mem=1 (hold):
  - Pipeline fields keep their previous values.
  - hilo_temp_o loads hilo_temp_i; cnt_o loads cnt_i.
- stall_ex=0 with stall_mem=1 is illegal from the stall controller. The block treats it exactly as hold: the MEM instruction is not overwritten and no instruction is dropped.
- A bubble never produces a GPR or HI/LO write: we_o=0, we_hilo_o=0, waddr_o=0.
- MADD/MSUB sequence:
  - Execute asserts stall_ex with cnt_i=1 and the product on hilo_temp_i.
  - Next cycle execute sees cnt_o=1 and hilo_temp_o, completes, and deasserts stall_ex.
  - On that edge the result advances and cnt_o/hilo_temp_o return to 0.
- cnt is a pass-through; it has no internal wrap. Values 2 and 3 are carried unchanged.
- Reset or flush mid-accumulate discards hilo_temp/cnt. Execute then restarts from cnt=0.

Test Plan:
- Reset: drive all inputs nonzero, rst=1 for 1 edge -> every output 0. Deassert rst, stalls 0, we_i=1, waddr_i=5, wdata_i=32'h1234 -> next edge we_o=1, waddr_o=5, wdata_o=32'h1234, valid_o=1.
- Bubble: after a valid capture of waddr=5, set stall_ex=1, stall_mem=0, waddr_i=7 -> next edge valid_o=0, we_o=0, waddr_o=0. Release stall -> waddr_o=7.
- Hold: capture wdata=32'hAAAA_0001, then stall_ex=stall_mem=1 for 3 cycles with wdata_i changing -> wdata_o stays 32'hAAAA_0001 all 3 cycles. Repeat with stall_ex=0, stall_mem=1 -> same hold.
- Accumulate: stall_ex=1, stall_mem=0, cnt_i=1, hilo_temp_i=64'h0000_0002_0000_0003 -> cnt_o=1, hilo_temp_o equals that value. Next edge stall_ex=0, we_hilo_i=1, hi_i=2, lo_i=9 -> we_hilo_o=1, hi_o=2, lo_o=9, cnt_o=0, hilo_temp_o=0.
- Flush priority: flush=1 together with stall_ex=stall_mem=1 while holding we_o=1 -> next edge all pipeline outputs 0, cnt_o=0, hilo_temp_o=0.
- Mid-accumulate reset: cnt_o=1, hilo_temp_o nonzero, rst=1 -> next edge cnt_o=0, hilo_temp_o=0, all outputs 0.

Source files
------------

// File: rtl/reg_ex_mem_if.sv
// EX/MEM pipeline register bundle: execute-side inputs, MEM-side outputs,
// stall/flush controls and the MADD/MSUB accumulate feedback (hilo_temp, cnt).
interface reg_ex_mem_if;
  logic        stall_ex;
  logic        stall_mem;
  logic        flush;

  logic        valid_i;
  logic [7:0]  aluop_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        we_hilo_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;

  logic        valid_o;
  logic [7:0]  aluop_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        we_hilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  modport master (
    output stall_ex, stall_mem, flush,
    output valid_i, aluop_i, we_i, waddr_i, wdata_i,
    output we_hilo_i, hi_i, lo_i, mem_addr_i, mem_data_i,
    output hilo_temp_i, cnt_i,
    input  valid_o, aluop_o, we_o, waddr_o, wdata_o,
    input  we_hilo_o, hi_o, lo_o, mem_addr_o, mem_data_o,
    input  hilo_temp_o, cnt_o
  );

  modport slave (
    input  stall_ex, stall_mem, flush,
    input  valid_i, aluop_i, we_i, waddr_i, wdata_i,
    input  we_hilo_i, hi_i, lo_i, mem_addr_i, mem_data_i,
    input  hilo_temp_i, cnt_i,
    output valid_o, aluop_o, we_o, waddr_o, wdata_o,
    output we_hilo_o, hi_o, lo_o, mem_addr_o, mem_data_o,
    output hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/reg_ex_mem.sv
// EX/MEM pipeline register with bubble/hold/flush and MADD/MSUB feedback.
// Ports: clk, rst (sync, active-high), bus (reg_ex_mem_if.slave).
module reg_ex_mem (
  input logic         clk,
  input logic         rst,
  reg_ex_mem_if.slave bus
);

  logic        r_valid;
  logic [7:0]  r_aluop;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_we_hilo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic [63:0] r_hilo_temp;
  logic [1:0]  r_cnt;

  logic w_adv;
  logic w_bub;
  logic w_acc;

  // stall_mem alone (illegal) falls into hold so MEM is never overwritten
  assign w_adv = ~bus.stall_ex & ~bus.stall_mem;
  assign w_bub =  bus.stall_ex & ~bus.stall_mem;
  assign w_acc =  bus.stall_ex |  bus.stall_mem;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid    <= 1'b0;
      r_aluop    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_we_hilo  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_adv) begin
      r_valid    <= bus.valid_i;
      r_aluop    <= bus.aluop_i;
      r_we       <= bus.we_i;
      r_waddr    <= bus.waddr_i;
      r_wdata    <= bus.wdata_i;
      r_we_hilo  <= bus.we_hilo_i;
      r_hi       <= bus.hi_i;
      r_lo       <= bus.lo_i;
      r_mem_addr <= bus.mem_addr_i;
      r_mem_data <= bus.mem_data_i;
    end else if (w_bub) begin
      r_valid    <= 1'b0;
      r_aluop    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_we_hilo  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end
  end

  // accumulate state only survives while execute is held
  always_ff @(posedge clk) begin
    if (rst || bus.flush || !w_acc) begin
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else begin
      r_hilo_temp <= bus.hilo_temp_i;
      r_cnt       <= bus.cnt_i;
    end
  end

  assign bus.valid_o     = r_valid;
  assign bus.aluop_o     = r_aluop;
  assign bus.we_o        = r_we;
  assign bus.waddr_o     = r_waddr;
  assign bus.wdata_o     = r_wdata;
  assign bus.we_hilo_o   = r_we_hilo;
  assign bus.hi_o        = r_hi;
  assign bus.lo_o        = r_lo;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_data_o  = r_mem_data;
  assign bus.hilo_temp_o = r_hilo_temp;
  assign bus.cnt_o       = r_cnt;

endmodule
